// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: arbitrates the single RAM port between instruction fetch and load/store data.
// The requester latched in IDLE is size/alignment checked, and then the MFA/MFC handshake runs for it.
// Optional macro RAM_TIMEOUT_EN aborts an access that waits TIMEOUT cycles for ramMFC without seeing it.
module ram_access_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchDone,
  input  logic              dataReq,
  input  logic              dataRW,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [1:0]        dataSize,
  output logic              dataDone,
  output logic              accErr,
  output logic              accOwner,
  output logic              busy,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [1:0]        ramDataSize,
  input  logic              ramMFC
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_ACCESS  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;
  logic [1:0]        r_state;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              w_err;
`ifdef RAM_TIMEOUT_EN
  logic [7:0]        r_cnt;
`endif
  // Reserved size, odd halfword or non-word-aligned word is refused before touching RAM.
  assign w_err = (r_size == 2'b11) | ((r_size == 2'b01) & r_addr[0]) | ((r_size == 2'b10) & (|r_addr[1:0]));
  assign busy  = (r_state != S_IDLE);
  // Sequencer: grant in IDLE (data first), check, run the handshake, then wait for MFC to drop.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_size      <= 2'b00;
      fetchDone   <= 1'b0;
      dataDone    <= 1'b0;
      accErr      <= 1'b0;
      accOwner    <= 1'b0;
      ramMFA      <= 1'b0;
      ramRW       <= 1'b0;
      ramAddress  <= '0;
      ramDataSize <= 2'b00;
`ifdef RAM_TIMEOUT_EN
      r_cnt       <= 8'd0;
`endif
    end else begin
      fetchDone <= 1'b0;
      dataDone  <= 1'b0;
      accErr    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dataReq) begin
            r_rw     <= dataRW;
            r_addr   <= dataAddr;
            r_size   <= dataSize;
            accOwner <= 1'b1;
            r_state  <= S_CHECK;
          end else if (fetchReq) begin
            r_rw     <= 1'b1;
            r_addr   <= fetchAddr;
            r_size   <= 2'b10;
            accOwner <= 1'b0;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_err) begin
            fetchDone <= ~accOwner;
            dataDone  <= accOwner;
            accErr    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            ramMFA      <= 1'b1;
            ramRW       <= r_rw;
            ramAddress  <= r_addr;
            ramDataSize <= r_size;
            r_state     <= S_ACCESS;
`ifdef RAM_TIMEOUT_EN
            r_cnt       <= 8'd0;
`endif
          end
        end
        S_ACCESS: begin
          if (ramMFC) begin
            ramMFA    <= 1'b0;
            fetchDone <= ~accOwner;
            dataDone  <= accOwner;
            r_state   <= S_RELEASE;
          end
`ifdef RAM_TIMEOUT_EN
          else if (r_cnt == 8'(TIMEOUT - 1)) begin
            ramMFA    <= 1'b0;
            fetchDone <= ~accOwner;
            dataDone  <= accOwner;
            accErr    <= 1'b1;
            r_state   <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        default: begin
          if (!ramMFC) r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer: scoreboard bench for ram_access_sequencer (default build, no timeout).
module tb_ram_access_sequencer;
  logic       Clk = 1'b0;
  logic       reset;
  logic       fetchReq;
  logic [8:0] fetchAddr;
  logic       fetchDone;
  logic       dataReq;
  logic       dataRW;
  logic [8:0] dataAddr;
  logic [1:0] dataSize;
  logic       dataDone;
  logic       accErr;
  logic       accOwner;
  logic       busy;
  logic       ramMFA;
  logic       ramRW;
  logic [8:0] ramAddress;
  logic [1:0] ramDataSize;
  logic       ramMFC;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] q[$];
  logic [1:0] e;

  always #5 Clk = ~Clk;

  ram_access_sequencer #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .Clk(Clk), .reset(reset),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchDone(fetchDone),
    .dataReq(dataReq), .dataRW(dataRW), .dataAddr(dataAddr), .dataSize(dataSize), .dataDone(dataDone),
    .accErr(accErr), .accOwner(accOwner), .busy(busy),
    .ramMFA(ramMFA), .ramRW(ramRW), .ramAddress(ramAddress), .ramDataSize(ramDataSize), .ramMFC(ramMFC)
  );

  // Scoreboard: every done pulse pops one expected {owner, err} pushed when the request was driven.
  always @(negedge Clk) begin
    if (fetchDone && dataDone) begin
      n_tests++;
      n_fail++;
      $display("FAIL both_done: fetchDone and dataDone high together");
    end else if (fetchDone || dataDone) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got fetchDone=%b dataDone=%b with nothing expected", fetchDone, dataDone);
      end else begin
        e = q.pop_front();
        if ({dataDone, accErr, accOwner} !== {e[1], e[0], e[1]}) begin
          n_fail++;
          $display("FAIL done_scoreboard: got dataDone/accErr/accOwner=%b%b%b expected %b%b%b",
                   dataDone, accErr, accOwner, e[1], e[0], e[1]);
        end
      end
    end
  end

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_tests++;
    if ({fetchDone, dataDone, accErr, accOwner, busy, ramMFA, ramRW, ramAddress, ramDataSize} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {fetchDone, dataDone, accErr, accOwner, busy, ramMFA, ramRW, ramAddress, ramDataSize});
    end
    reset = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fetch();
    fetchAddr = 9'h010;
    fetchReq  = 1'b1;
    q.push_back(2'b00);
    step();
    n_tests++;
    if ({busy, ramMFA} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_check: got busy/ramMFA=%b expected 10", {busy, ramMFA});
    end
    step();
    n_tests++;
    if ({ramMFA, ramRW, ramAddress, ramDataSize} !== {1'b1, 1'b1, 9'h010, 2'b10}) begin
      n_fail++;
      $display("FAIL fetch_access: got mfa/rw/addr/size=%b/%b/%h/%b expected 1/1/010/10",
               ramMFA, ramRW, ramAddress, ramDataSize);
    end
    step();
    ramMFC = 1'b1;
    step();
    n_tests++;
    if ({fetchDone, ramMFA, accOwner} !== 3'b100) begin
      n_fail++;
      $display("FAIL fetch_done: got fetchDone/ramMFA/accOwner=%b expected 100", {fetchDone, ramMFA, accOwner});
    end
    fetchReq = 1'b0;
    ramMFC   = 1'b0;
    step();
    n_tests++;
    if ({fetchDone, busy, ramAddress, ramDataSize} !== {1'b0, 1'b0, 9'h010, 2'b10}) begin
      n_fail++;
      $display("FAIL fetch_after: got done/busy/addr/size=%b/%b/%h/%b expected 0/0/010/10",
               fetchDone, busy, ramAddress, ramDataSize);
    end
  endtask

  task automatic test_back_to_back();
    fetchAddr = 9'h020;
    fetchReq  = 1'b1;
    dataAddr  = 9'h003;
    dataSize  = 2'b00;
    dataRW    = 1'b0;
    dataReq   = 1'b1;
    q.push_back(2'b10);
    q.push_back(2'b00);
    step();
    n_tests++;
    if ({busy, accOwner} !== 2'b11) begin
      n_fail++;
      $display("FAIL prio_owner: got busy/accOwner=%b expected 11", {busy, accOwner});
    end
    step();
    n_tests++;
    if ({ramMFA, ramRW, ramAddress, ramDataSize} !== {1'b1, 1'b0, 9'h003, 2'b00}) begin
      n_fail++;
      $display("FAIL prio_access: got mfa/rw/addr/size=%b/%b/%h/%b expected 1/0/003/00",
               ramMFA, ramRW, ramAddress, ramDataSize);
    end
    ramMFC = 1'b1;
    step();
    n_tests++;
    if (dataDone !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_done: got dataDone=%b expected 1", dataDone);
    end
    dataReq = 1'b0;
    step();
    step();
    n_tests++;
    if ({busy, ramMFA, accOwner} !== 3'b101) begin
      n_fail++;
      $display("FAIL release_hold: got busy/ramMFA/accOwner=%b expected 101", {busy, ramMFA, accOwner});
    end
    ramMFC = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle: got busy=%b expected 0", busy);
    end
    step();
    n_tests++;
    if ({busy, accOwner} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_grant: got busy/accOwner=%b expected 10", {busy, accOwner});
    end
    step();
    n_tests++;
    if ({ramMFA, ramRW, ramAddress, ramDataSize} !== {1'b1, 1'b1, 9'h020, 2'b10}) begin
      n_fail++;
      $display("FAIL fetch2_access: got mfa/rw/addr/size=%b/%b/%h/%b expected 1/1/020/10",
               ramMFA, ramRW, ramAddress, ramDataSize);
    end
    ramMFC = 1'b1;
    step();
    fetchReq = 1'b0;
    ramMFC   = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    logic [8:0] addrs[3] = '{9'h006, 9'h000, 9'h005};
    logic [1:0] sizes[3] = '{2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 3; i++) begin
      dataAddr = addrs[i];
      dataSize = sizes[i];
      dataRW   = 1'b1;
      dataReq  = 1'b1;
      q.push_back(2'b11);
      step();
      n_tests++;
      if ({busy, ramMFA, dataDone} !== 3'b100) begin
        n_fail++;
        $display("FAIL err_check_%0d: got busy/ramMFA/dataDone=%b expected 100", i, {busy, ramMFA, dataDone});
      end
      step();
      n_tests++;
      if ({dataDone, accErr, ramMFA, busy} !== 4'b1100) begin
        n_fail++;
        $display("FAIL err_done_%0d: got dataDone/accErr/ramMFA/busy=%b expected 1100", i,
                 {dataDone, accErr, ramMFA, busy});
      end
      dataReq = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    fetchAddr = 9'h040;
    fetchReq  = 1'b1;
    step();
    step();
    n_tests++;
    if (ramMFA !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_access: got ramMFA=%b expected 1", ramMFA);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if ({ramMFA, busy, fetchDone, dataDone} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got mfa/busy/fd/dd=%b expected 0000", {ramMFA, busy, fetchDone, dataDone});
    end
    reset = 1'b1;
    q.push_back(2'b00);
    step();
    step();
    n_tests++;
    if ({ramMFA, ramAddress} !== {1'b1, 9'h040}) begin
      n_fail++;
      $display("FAIL rst_recover: got mfa/addr=%b/%h expected 1/040", ramMFA, ramAddress);
    end
    ramMFC = 1'b1;
    step();
    n_tests++;
    if (fetchDone !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_recover_done: got fetchDone=%b expected 1", fetchDone);
    end
    fetchReq = 1'b0;
    ramMFC   = 1'b0;
    step();
  endtask

  task automatic test_drop();
    dataAddr = 9'h008;
    dataSize = 2'b10;
    dataRW   = 1'b1;
    dataReq  = 1'b1;
    q.push_back(2'b10);
    step();
    step();
    dataReq  = 1'b0;
    dataAddr = 9'h1FF;
    step();
    step();
    n_tests++;
    if ({ramMFA, ramAddress, busy} !== {1'b1, 9'h008, 1'b1}) begin
      n_fail++;
      $display("FAIL drop_hold: got mfa/addr/busy=%b/%h/%b expected 1/008/1", ramMFA, ramAddress, busy);
    end
    ramMFC = 1'b1;
    step();
    n_tests++;
    if (dataDone !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_done: got dataDone=%b expected 1", dataDone);
    end
    ramMFC = 1'b0;
    step();
    step();
    n_tests++;
    if ({busy, dataDone} !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_idle: got busy/dataDone=%b expected 00", {busy, dataDone});
    end
  endtask

  task automatic test_no_timeout();
    int drops = 0;
    fetchAddr = 9'h0C0;
    fetchReq  = 1'b1;
    q.push_back(2'b00);
    step();
    for (int i = 0; i < 50; i++) begin
      step();
      if (ramMFA !== 1'b1) drops++;
    end
    n_tests++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL no_timeout: got %0d cycles with ramMFA low expected 0", drops);
    end
    ramMFC = 1'b1;
    step();
    n_tests++;
    if ({fetchDone, accErr} !== 2'b10) begin
      n_fail++;
      $display("FAIL long_done: got fetchDone/accErr=%b expected 10", {fetchDone, accErr});
    end
    fetchReq = 1'b0;
    ramMFC   = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset     = 1'b0;
    fetchReq  = 1'b0;
    fetchAddr = '0;
    dataReq   = 1'b0;
    dataRW    = 1'b0;
    dataAddr  = '0;
    dataSize  = 2'b00;
    ramMFC    = 1'b0;
    test_reset();
    test_fetch();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    test_drop();
    test_no_timeout();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending done pulses expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
